// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  // Fetch wins after this many consecutive lost arbitrations.
  localparam int unsigned STARVE_LIM_DEF = 3;

  // Width of the starvation counter; covers limits 1..15.
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive arbitrations that fetch has lost.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic at_lim
);

  localparam logic [STARVE_CNT_W-1:0] LimV = STARVE_CNT_W'(LIM);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != LimV)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_lim = (cnt_q == LimV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant periodically.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic arb_pt;
  logic d_win;
  logic if_win;
  logic starve_tick;
  logic starve_clear;
  logic at_lim;

  // Winner pick at arbitration points; no grant while reset is held,
  // since nothing would be latched and the requester would drop its request.
  always_comb begin
    arb_pt       = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
    d_win        = arb_pt && !reset && d_req && !(if_req && at_lim);
    if_win       = arb_pt && !reset && if_req && !d_win;
    starve_tick  = arb_pt && if_req && d_win;
    starve_clear = arb_pt && (if_win || !if_req);
  end

  mem_arb_starve_ctr #(
    .LIM (STARVE_LIM)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .tick   (starve_tick),
    .clear  (starve_clear),
    .at_lim (at_lim)
  );

  // Next-state: latch the winner's request, wait for mem_ready, capture read data.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ARB_IDLE, ARB_RESP: begin
        if (d_win) begin
          state_d = ARB_ACCESS;
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (if_win) begin
          state_d = ARB_ACCESS;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        if (mem_ready) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata[31:0];
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and latch registers; everything visible on the ports clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign mem_req   = (state_q == ARB_ACCESS);
  assign mem_we    = (state_q == ARB_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = (state_q == ARB_RESP) && (owner_q == OWN_IF);
  assign d_valid   = (state_q == ARB_RESP) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the two requesters.
module tb_mem_port_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int LIM    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_valid;
  logic [31:0]       if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int waits_cfg   = 0;

  logic [DATA_W-1:0] mem_model [0:511];
  logic [DATA_W-1:0] gold      [0:511];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_LIM (LIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory responder: waits_cfg wait states per access, random noise when idle.
  initial begin : responder
    int wcnt;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) begin
        if (wcnt >= waits_cfg) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model[mem_addr];
          if (mem_we === 1'b1) mem_model[mem_addr] = mem_wdata;
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = {$urandom, $urandom};
          wcnt++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
        wcnt = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, busy, if_valid, d_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, busy, if_valid, d_valid});
    end
    vectors++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_gnt: got %b want 00", {if_gnt, d_gnt});
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    vectors++;
    if (if_rdata !== '0 || d_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata);
    end
  endtask

  task automatic test_single_fetch();
    mem_model[9'h010] = 64'h0000_0000_0050_0093;
    gold[9'h010]      = 64'h0000_0000_0050_0093;
    waits_cfg = 0;
    cyc();
    if_req  = 1'b1;
    if_addr = 9'h010;
    #1;
    vectors++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt});
    end
    cyc();
    if_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 9'h010}) begin
      miscompares++;
      $display("FAIL fetch_access: got %b %b %h want 1 0 010", mem_req, mem_we, mem_addr);
    end
    cyc();
    #1;
    vectors++;
    if ({if_valid, d_valid, mem_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL fetch_resp: got %b want 100", {if_valid, d_valid, mem_req});
    end
    vectors++;
    if (if_rdata !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL fetch_rdata: got %h want 00500093", if_rdata);
    end
    cyc();
    #1;
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_valid_pulse: got %b want 0", if_valid);
    end
  endtask

  task automatic test_store_load();
    waits_cfg = 0;
    cyc();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 9'h020;
    d_wdata = 64'hDEAD_BEEF_0123_4567;
    #1;
    vectors++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL store_gnt: got %b want 01", {if_gnt, d_gnt});
    end
    cyc();
    d_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h020, 64'hDEAD_BEEF_0123_4567}) begin
      miscompares++;
      $display("FAIL store_access: got %b %b %h %h", mem_req, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    d_req = 1'b1;
    d_we  = 1'b0;
    #1;
    vectors++;
    if ({d_valid, if_valid, d_gnt} !== 3'b101) begin
      miscompares++;
      $display("FAIL store_resp_b2b: got %b want 101", {d_valid, if_valid, d_gnt});
    end
    vectors++;
    if (d_rdata !== 64'h0) begin
      miscompares++;
      $display("FAIL store_keeps_rdata: got %h want 0", d_rdata);
    end
    gold[9'h020] = 64'hDEAD_BEEF_0123_4567;
    cyc();
    d_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 9'h020}) begin
      miscompares++;
      $display("FAIL load_access: got %b %b %h want 1 0 020", mem_req, mem_we, mem_addr);
    end
    cyc();
    #1;
    vectors++;
    if (d_valid !== 1'b1 || d_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      miscompares++;
      $display("FAIL load_rdata: got %b %h want 1 deadbeef01234567", d_valid, d_rdata);
    end
    cyc();
  endtask

  task automatic test_starvation();
    logic exp_if [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int ng, last, cycles;
    ng = 0;
    last = 0;
    cycles = 0;
    waits_cfg = 0;
    cyc();
    if_req  = 1'b1;
    if_addr = 9'h030;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 9'h031;
    while (ng < 8 && cycles < 40) begin
      #1;
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        vectors++;
        if ({if_gnt, d_gnt} !== (exp_if[ng] ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL starve_order[%0d]: got %b want %b", ng, {if_gnt, d_gnt},
                   (exp_if[ng] ? 2'b10 : 2'b01));
        end
        if (ng > 0) begin
          vectors++;
          if (cycles - last != 2) begin
            miscompares++;
            $display("FAIL starve_b2b_gap[%0d]: got %0d want 2", ng, cycles - last);
          end
        end
        last = cycles;
        ng++;
      end
      cyc();
      cycles++;
    end
    if (ng < 8) begin
      vectors++;
      miscompares++;
      $display("FAIL starve_timeout: got %0d grants want 8", ng);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_wait_states();
    int nvalid;
    nvalid = 0;
    waits_cfg = 4;
    cyc();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 9'h020;
    #1;
    vectors++;
    if (d_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_gnt: got %b want 1", d_gnt);
    end
    cyc();
    d_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (d_valid === 1'b1) nvalid++;
      vectors++;
      if ({mem_req, mem_addr} !== {1'b1, 9'h020}) begin
        miscompares++;
        $display("FAIL wait_access[%0d]: got %b %h want 1 020", i, mem_req, mem_addr);
      end
      cyc();
    end
    #1;
    if (d_valid === 1'b1) nvalid++;
    vectors++;
    if ({d_valid, mem_req} !== 2'b10 || d_rdata !== gold[9'h020]) begin
      miscompares++;
      $display("FAIL wait_resp: got %b %h want 10 %h", {d_valid, mem_req}, d_rdata, gold[9'h020]);
    end
    cyc();
    #1;
    if (d_valid === 1'b1) nvalid++;
    vectors++;
    if (nvalid != 1) begin
      miscompares++;
      $display("FAIL wait_valid_count: got %0d want 1", nvalid);
    end
    waits_cfg = 0;
  endtask

  task automatic test_reset_mid_access();
    waits_cfg = 1;
    cyc();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 9'h0AB;
    #1;
    vectors++;
    if (d_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_gnt: got %b want 1", d_gnt);
    end
    cyc();
    d_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, busy, if_valid, d_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL rstmid_ctrl: got %b want 00000", {mem_req, mem_we, busy, if_valid, d_valid});
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      miscompares++;
      $display("FAIL rstmid_data: got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    cyc();
    #1;
    vectors++;
    if ({d_valid, mem_req, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_after: got %b want 000", {d_valid, mem_req, busy});
    end
    waits_cfg = 0;
  endtask

  task automatic test_random();
    localparam int NIF = 60;
    localparam int ND  = 60;
    logic              if_pend, d_pend, outstanding, o_if, o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata, exp_d;
    logic [31:0]       exp_i;
    logic [1:0]        exp_g;
    int                if_iss, d_iss, done, losses, cycles;
    if_pend = 1'b0; d_pend = 1'b0; outstanding = 1'b0;
    o_if = 1'b0; o_we = 1'b0; o_addr = '0; o_wdata = '0;
    exp_d = '0; exp_i = '0;
    if_iss = 0; d_iss = 0; done = 0; losses = 0; cycles = 0;
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    cyc();
    reset = 1'b0;
    while (done < NIF + ND && cycles < 3000) begin
      cyc();
      cycles++;
      if (!if_pend && if_iss < NIF && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1;
        if_addr = 9'($urandom_range(0, 15));
        if_iss++;
      end
      if (!d_pend && d_iss < ND && $urandom_range(0, 2) != 0) begin
        d_pend  = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 9'($urandom_range(0, 15));
        d_wdata = {$urandom, $urandom};
        d_iss++;
      end
      if_req = if_pend;
      d_req  = d_pend;
      #1;
      if (if_valid === 1'b1 || d_valid === 1'b1) begin
        vectors++;
        if (!outstanding) begin
          miscompares++;
          $display("FAIL rnd_spurious_valid: got %b want 00", {if_valid, d_valid});
        end else begin
          if ({if_valid, d_valid} !== (o_if ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL rnd_valid_owner: got %b want %b", {if_valid, d_valid}, (o_if ? 2'b10 : 2'b01));
          end
          vectors++;
          if (o_if) begin
            exp_i = gold[o_addr][31:0];
            if (if_rdata !== exp_i) begin
              miscompares++;
              $display("FAIL rnd_fetch_data: got %h want %h", if_rdata, exp_i);
            end
          end else if (o_we) begin
            gold[o_addr] = o_wdata;
            if (d_rdata !== exp_d) begin
              miscompares++;
              $display("FAIL rnd_store_keeps_rdata: got %h want %h", d_rdata, exp_d);
            end
          end else begin
            exp_d = gold[o_addr];
            if (d_rdata !== exp_d) begin
              miscompares++;
              $display("FAIL rnd_load_data: got %h want %h", d_rdata, exp_d);
            end
          end
          outstanding = 1'b0;
          done++;
        end
      end
      if (outstanding) begin
        vectors++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, (!o_if && o_we), o_addr} ||
            (!o_if && o_we && mem_wdata !== o_wdata)) begin
          miscompares++;
          $display("FAIL rnd_mem_bus: got %b %b %h %h want 1 %b %h %h", mem_req, mem_we,
                   mem_addr, mem_wdata, (!o_if && o_we), o_addr, o_wdata);
        end
      end
      exp_g = 2'b00;
      if (!outstanding) begin
        if (d_pend && if_pend) exp_g = (losses == LIM) ? 2'b10 : 2'b01;
        else if (d_pend)       exp_g = 2'b01;
        else if (if_pend)      exp_g = 2'b10;
        if (exp_g == 2'b01 && if_pend) losses++;
        else                           losses = 0;
      end
      vectors++;
      if ({if_gnt, d_gnt} !== exp_g) begin
        miscompares++;
        $display("FAIL rnd_grant: got %b want %b (cycle %0d)", {if_gnt, d_gnt}, exp_g, cycles);
      end
      if (exp_g != 2'b00) begin
        outstanding = 1'b1;
        o_if = exp_g[1];
        if (o_if) begin
          o_we    = 1'b0;
          o_addr  = if_addr;
          if_pend = 1'b0;
        end else begin
          o_we    = d_we;
          o_addr  = d_addr;
          o_wdata = d_wdata;
          d_pend  = 1'b0;
        end
        waits_cfg = int'($urandom_range(0, 2));
      end
    end
    vectors++;
    if (done != NIF + ND) begin
      miscompares++;
      $display("FAIL rnd_completion: got %0d want %0d", done, NIF + ND);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      mem_model[i] = {$urandom, $urandom};
      gold[i]      = mem_model[i];
    end
    test_reset();
    test_single_fetch();
    test_store_load();
    test_starvation();
    test_wait_states();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
